vend_ctrl_multi: RTL

//  Parametrised successor of the single-coin coffee vendor. Accepts N coin

---
 rtl/vend_ctrl_multi.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl_multi.sv
// Multi-coin, multi-product vending controller: running credit, priced selections,
// and change returned one credit unit per cycle on CANCEL, after a vend, or on idle timeout.
module vend_ctrl_multi #(
    parameter int                         CREDIT_W   = 8,
    parameter int                         N_PROD     = 4,
    parameter int                         SEL_W      = 2,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICE_VEC  = {8'd20, 8'd15, 8'd10, 8'd5},
    parameter logic [4*CREDIT_W-1:0]      COIN_VEC   = {8'd10, 8'd5, 8'd2, 8'd1},
    parameter int                         CREDIT_MAX = 50,
    parameter int                         TIMEOUT    = 100
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                C_IN,
    input  logic [1:0]          C_SEL,
    input  logic                B_IN,
    input  logic [SEL_W-1:0]    B_SEL,
    input  logic                CANCEL,
    output logic                COFF,
    output logic [SEL_W-1:0]    COFF_ID,
    output logic                BAL,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic                C_REJ,
    output logic                B_REJ,
    output logic                BUSY
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W:0] MAX_EXT  = (CREDIT_W + 1)'(CREDIT_MAX);
    localparam logic [SEL_W:0]    NP_EXT   = (SEL_W + 1)'(N_PROD);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

    // Bit 1 of the encoding marks the busy states so BUSY is a plain register bit.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CREDIT = 2'b01,
        S_VEND   = 2'b10,
        S_REFUND = 2'b11
    } state_t;

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [TW-1:0]       r_timer;
    logic                r_coff;
    logic [SEL_W-1:0]    r_coff_id;
    logic                r_bal;
    logic                r_crej;
    logic                r_brej;

    logic [CREDIT_W-1:0] w_coin;
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W:0]   w_sum;
    logic                w_sel_ok;
    logic                w_coin_ok;
    logic                w_can_buy;

    always_comb begin
        w_coin  = '0;
        w_price = '0;
        for (int i = 0; i < 4; i++) begin
            if (C_SEL == 2'(i)) w_coin = COIN_VEC[i*CREDIT_W +: CREDIT_W];
        end
        for (int i = 0; i < N_PROD; i++) begin
            if (B_SEL == SEL_W'(i)) w_price = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
        end
        w_sum     = {1'b0, r_credit} + {1'b0, w_coin};
        w_coin_ok = (w_sum <= MAX_EXT);
        w_sel_ok  = ({1'b0, B_SEL} < NP_EXT);
        w_can_buy = w_sel_ok && (r_credit >= w_price);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_credit  <= '0;
            r_timer   <= '0;
            r_coff    <= 1'b0;
            r_coff_id <= '0;
            r_bal     <= 1'b0;
            r_crej    <= 1'b0;
            r_brej    <= 1'b0;
        end else begin
            r_coff    <= 1'b0;
            r_coff_id <= '0;
            r_bal     <= 1'b0;
            r_crej    <= 1'b0;
            r_brej    <= 1'b0;
            case (r_state)
                S_IDLE, S_CREDIT: begin
                    if (CANCEL && (r_state == S_CREDIT)) begin
                        r_state  <= S_REFUND;
                        r_bal    <= 1'b1;
                        r_credit <= r_credit - 1'b1;
                        r_timer  <= '0;
                        r_brej   <= B_IN;
                        r_crej   <= C_IN;
                    end else if (B_IN && w_can_buy) begin
                        r_state   <= S_VEND;
                        r_coff    <= 1'b1;
                        r_coff_id <= B_SEL;
                        r_credit  <= r_credit - w_price;
                        r_timer   <= '0;
                        r_crej    <= C_IN;
                    end else begin
                        r_brej <= B_IN;
                        if (C_IN) begin
                            if (w_coin_ok) begin
                                r_credit <= w_sum[CREDIT_W-1:0];
                                r_state  <= (w_sum == '0) ? S_IDLE : S_CREDIT;
                            end else begin
                                r_crej <= 1'b1;
                            end
                        end
                        // Any strobe restarts the inactivity window; only CREDIT counts.
                        if (B_IN || C_IN) begin
                            r_timer <= '0;
                        end else if (r_state == S_CREDIT) begin
                            if (r_timer == TMO_LAST) begin
                                r_timer  <= '0;
                                r_state  <= S_REFUND;
                                r_bal    <= 1'b1;
                                r_credit <= r_credit - 1'b1;
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                    end
                end
                S_VEND: begin
                    r_crej <= C_IN;
                    r_brej <= B_IN;
                    if (r_credit != '0) begin
                        r_state  <= S_REFUND;
                        r_bal    <= 1'b1;
                        r_credit <= r_credit - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REFUND: begin
                    r_crej <= C_IN;
                    r_brej <= B_IN;
                    if (r_credit != '0) begin
                        r_bal    <= 1'b1;
                        r_credit <= r_credit - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign COFF    = r_coff;
    assign COFF_ID = r_coff_id;
    assign BAL     = r_bal;
    assign CREDIT  = r_credit;
    assign C_REJ   = r_crej;
    assign B_REJ   = r_brej;
    assign BUSY    = r_state[1];

endmodule
